// File: rtl/arm_pkg.sv
// Shared fetch-stage types and constants for the ARM pipeline slice.
package arm_pkg;

   localparam int PC_W_DEF    = 32;
   localparam int INSTR_W_DEF = 32;
   localparam int PC_INC      = 4;

   typedef enum logic [1:0] {
      FETCH,
      DRAIN,
      HOLD
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Priority: flush > freeze > load > bubble (bubble clears only the valid bit).
module if_id_reg #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_flush,
   input  logic               i_freeze,
   input  logic               i_load,
   input  logic               i_bubble,
   input  logic [PC_W-1:0]    i_pc,
   input  logic [INSTR_W-1:0] i_instr,
   output logic [PC_W-1:0]    o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic               o_valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_pc    <= '0;
         o_instr <= '0;
         o_valid <= 1'b0;
      end else if (i_flush) begin
         o_pc    <= '0;
         o_instr <= '0;
         o_valid <= 1'b0;
      end else if (i_freeze) begin
         o_valid <= o_valid;
      end else if (i_load) begin
         o_pc    <= i_pc;
         o_instr <= i_instr;
         o_valid <= 1'b1;
      end else if (i_bubble) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, IF/ID load, hazard freeze and branch redirect.
// Defining FETCH_PERF_EN adds the freeze_cnt/flush_cnt performance counters.
module fetch_unit
   import arm_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hazard_detected,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_addr,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [PC_W-1:0]    if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        freeze_cnt,
   output logic [31:0]        flush_cnt
`endif
);

   fetch_state_t       r_state, w_nextState;
   logic [PC_W-1:0]    r_pc, w_pcNext, w_pcPlus4;
   logic [PC_W-1:0]    r_redirectPc, w_redirectNext;
   logic [PC_W-1:0]    r_holdPc;
   logic [INSTR_W-1:0] r_holdInstr;
   logic               w_holdLoad;
   logic               w_flush, w_freeze, w_load, w_bubble;
   logic [PC_W-1:0]    w_loadPc;
   logic [INSTR_W-1:0] w_loadInstr;

   assign w_pcPlus4 = r_pc + PC_W'(PC_INC);
   // Request is held low while reset is asserted so all outputs read zero during reset.
   assign imem_req  = (r_state != HOLD) && !rst;
   assign imem_addr = r_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= FETCH;
         r_pc         <= RESET_PC;
         r_redirectPc <= '0;
         r_holdPc     <= '0;
         r_holdInstr  <= '0;
      end else begin
         r_state      <= w_nextState;
         r_pc         <= w_pcNext;
         r_redirectPc <= w_redirectNext;
         if (w_holdLoad) begin
            r_holdPc    <= w_pcPlus4;
            r_holdInstr <= imem_rdata;
         end
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_pcNext       = r_pc;
      w_redirectNext = r_redirectPc;
      w_holdLoad     = 1'b0;
      w_flush        = 1'b0;
      w_freeze       = 1'b0;
      w_load         = 1'b0;
      w_bubble       = 1'b0;
      w_loadPc       = w_pcPlus4;
      w_loadInstr    = imem_rdata;
      case (r_state)
         FETCH: begin
            if (branch_taken) begin
               w_flush = 1'b1;
               if (imem_ready) begin
                  w_pcNext = branch_addr;
               end else begin
                  w_redirectNext = branch_addr;
                  w_nextState    = DRAIN;
               end
            end else if (hazard_detected) begin
               w_freeze = 1'b1;
               if (imem_ready) begin
                  w_holdLoad  = 1'b1;
                  w_nextState = HOLD;
               end
            end else if (imem_ready) begin
               w_load   = 1'b1;
               w_pcNext = w_pcPlus4;
            end else begin
               w_bubble = 1'b1;
            end
         end
         DRAIN: begin
            if (branch_taken) begin
               w_flush        = 1'b1;
               w_redirectNext = branch_addr;
            end else if (hazard_detected) begin
               w_freeze = 1'b1;
            end else begin
               w_bubble = 1'b1;
            end
            // The in-flight response is dropped; the newest redirect target wins.
            if (imem_ready) begin
               w_pcNext    = branch_taken ? branch_addr : r_redirectPc;
               w_nextState = FETCH;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               w_flush     = 1'b1;
               w_pcNext    = branch_addr;
               w_nextState = FETCH;
            end else if (hazard_detected) begin
               w_freeze = 1'b1;
            end else begin
               w_load      = 1'b1;
               w_loadPc    = r_holdPc;
               w_loadInstr = r_holdInstr;
               w_pcNext    = w_pcPlus4;
               w_nextState = FETCH;
            end
         end
         default: begin
            w_nextState = FETCH;
         end
      endcase
   end

   if_id_reg #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_ifId (
      .clk      (clk),
      .rst      (rst),
      .i_flush  (w_flush),
      .i_freeze (w_freeze),
      .i_load   (w_load),
      .i_bubble (w_bubble),
      .i_pc     (w_loadPc),
      .i_instr  (w_loadInstr),
      .o_pc     (if_id_pc),
      .o_instr  (if_id_instr),
      .o_valid  (if_id_valid)
   );

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         freeze_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (hazard_detected) freeze_cnt <= freeze_cnt + 32'd1;
         if (branch_taken)    flush_cnt  <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a configurable wait-state memory model.
// Expected values are hand-computed; rdata for an address a is a ^ 32'hE1A00000.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        hazard_detected;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] freeze_cnt;
   logic [31:0] flush_cnt;
`endif

   int unsigned waits;
   int unsigned waitCnt;
   int          checkCount;
   int          passCount;
   int          failCount;

   fetch_unit #(
      .PC_W     (32),
      .INSTR_W  (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .hazard_detected (hazard_detected),
      .branch_taken    (branch_taken),
      .branch_addr     (branch_addr),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .if_id_pc        (if_id_pc),
      .if_id_instr     (if_id_instr),
      .if_id_valid     (if_id_valid)
`ifdef FETCH_PERF_EN
      ,
      .freeze_cnt      (freeze_cnt),
      .flush_cnt       (flush_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory answers after 'waits' cycles of continuous request; 0 means same-cycle response.
   assign imem_ready = imem_req && (waitCnt == waits);
   assign imem_rdata = imem_addr ^ 32'hE1A0_0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             waitCnt <= 0;
      else if (imem_ready) waitCnt <= 0;
      else if (imem_req)   waitCnt <= waitCnt + 1;
   end

   task automatic applyStimulus(input logic haz, input logic br, input logic [31:0] addr);
      hazard_detected = haz;
      branch_taken    = br;
      branch_addr     = addr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      failCount  = 0;
      waits      = 0;
      rst        = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      checkOutput("rst_req",   32'(imem_req),    32'h0);
      checkOutput("rst_valid", 32'(if_id_valid), 32'h0);
      checkOutput("rst_pc",    if_id_pc,         32'h0);
      rst = 1'b0;
      #1;
      checkOutput("n0_req",   32'(imem_req),    32'h1);
      checkOutput("n0_addr",  imem_addr,        32'h0);
      checkOutput("n0_valid", 32'(if_id_valid), 32'h0);

      @(negedge clk);
      checkOutput("n1_addr",  imem_addr,        32'h4);
      checkOutput("n1_pc",    if_id_pc,         32'h4);
      checkOutput("n1_instr", if_id_instr,      32'hE1A0_0000);
      checkOutput("n1_valid", 32'(if_id_valid), 32'h1);

      @(negedge clk);
      checkOutput("n2_addr",  imem_addr,   32'h8);
      checkOutput("n2_pc",    if_id_pc,    32'h8);
      checkOutput("n2_instr", if_id_instr, 32'hE1A0_0004);
      applyStimulus(1'b1, 1'b0, 32'h0);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("hold_req",   32'(imem_req),    32'h0);
         checkOutput("hold_pc",    if_id_pc,         32'h8);
         checkOutput("hold_instr", if_id_instr,      32'hE1A0_0004);
         checkOutput("hold_valid", 32'(if_id_valid), 32'h1);
      end
      applyStimulus(1'b0, 1'b0, 32'h0);

      @(negedge clk);
      checkOutput("rel_req",   32'(imem_req),    32'h1);
      checkOutput("rel_addr",  imem_addr,        32'hC);
      checkOutput("rel_pc",    if_id_pc,         32'hC);
      checkOutput("rel_instr", if_id_instr,      32'hE1A0_0008);
      checkOutput("rel_valid", 32'(if_id_valid), 32'h1);
      waits = 2;

      @(negedge clk);
      checkOutput("w2a_addr",  imem_addr,        32'hC);
      checkOutput("w2a_valid", 32'(if_id_valid), 32'h0);
      @(negedge clk);
      checkOutput("w2b_addr",  imem_addr,        32'hC);
      @(negedge clk);
      checkOutput("w2c_addr",  imem_addr,        32'h10);
      checkOutput("w2c_pc",    if_id_pc,         32'h10);
      checkOutput("w2c_instr", if_id_instr,      32'hE1A0_000C);
      checkOutput("w2c_valid", 32'(if_id_valid), 32'h1);

      @(negedge clk);
      checkOutput("br_pre_addr", imem_addr, 32'h10);
      applyStimulus(1'b0, 1'b1, 32'h100);
      @(negedge clk);
      checkOutput("drain_req",   32'(imem_req),    32'h1);
      checkOutput("drain_addr",  imem_addr,        32'h10);
      checkOutput("drain_valid", 32'(if_id_valid), 32'h0);
      checkOutput("drain_instr", if_id_instr,      32'h0);
      checkOutput("drain_pc",    if_id_pc,         32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("redir_addr",  imem_addr,        32'h100);
      checkOutput("redir_valid", 32'(if_id_valid), 32'h0);
      checkOutput("redir_instr", if_id_instr,      32'h0);
      repeat (2) @(negedge clk);
      checkOutput("redir_wait_valid", 32'(if_id_valid), 32'h0);
      @(negedge clk);
      checkOutput("tgt_pc",    if_id_pc,         32'h104);
      checkOutput("tgt_instr", if_id_instr,      32'hE1A0_0100);
      checkOutput("tgt_valid", 32'(if_id_valid), 32'h1);
      checkOutput("tgt_addr",  imem_addr,        32'h104);
      waits = 0;
      applyStimulus(1'b1, 1'b0, 32'h0);

      @(negedge clk);
      checkOutput("hb_req", 32'(imem_req), 32'h0);
      checkOutput("hb_pc",  if_id_pc,      32'h104);
      applyStimulus(1'b1, 1'b1, 32'h40);
      @(negedge clk);
      checkOutput("hb_flush_addr",  imem_addr,        32'h40);
      checkOutput("hb_flush_valid", 32'(if_id_valid), 32'h0);
      checkOutput("hb_flush_instr", if_id_instr,      32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("hb_next_pc",    if_id_pc,    32'h44);
      checkOutput("hb_next_instr", if_id_instr, 32'hE1A0_0040);
      applyStimulus(1'b0, 1'b1, 32'h1C);

      @(negedge clk);
      checkOutput("b1c_addr", imem_addr, 32'h1C);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("b1c_pc",   if_id_pc,    32'h20);
      checkOutput("b1c_addr2", imem_addr,  32'h20);
      waits = 2;
      @(negedge clk);
      checkOutput("mid_addr", imem_addr, 32'h20);
      checkOutput("mid_pc",   if_id_pc,  32'h20);
      rst = 1'b1;
      #1;
      checkOutput("arst_req",   32'(imem_req),    32'h0);
      checkOutput("arst_addr",  imem_addr,        32'h0);
      checkOutput("arst_pc",    if_id_pc,         32'h0);
      checkOutput("arst_instr", if_id_instr,      32'h0);
      checkOutput("arst_valid", 32'(if_id_valid), 32'h0);

      @(negedge clk);
      rst   = 1'b0;
      waits = 0;
      #1;
      checkOutput("rel2_req",  32'(imem_req), 32'h1);
      checkOutput("rel2_addr", imem_addr,     32'h0);
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
      @(negedge clk);
      checkOutput("wrap_addr",  imem_addr,        32'hFFFF_FFFE);
      checkOutput("wrap_valid", 32'(if_id_valid), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("wrap_pc",    if_id_pc,    32'h0000_0002);
      checkOutput("wrap_instr", if_id_instr, 32'h1E5F_FFFE);
      checkOutput("wrap_next",  imem_addr,   32'h0000_0002);

`ifdef FETCH_PERF_EN
      applyStimulus(1'b1, 1'b0, 32'h0);
      repeat (5) @(negedge clk);
      applyStimulus(1'b0, 1'b1, 32'h80);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("freeze_cnt", freeze_cnt, 32'd5);
      checkOutput("flush_cnt",  flush_cnt,  32'd2);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
